ins_encoder: RTL and testbench
==============================

// Module: ins_encoder
// PURPOSE
//  Field-to-word instruction encoder, the producer side of the instruction register's
//  field split. Packs opCode/rs/rt/rd/sa/Immediate/j_addr into 32-bit instruction words.
//  Buffers the words in a small FIFO.
//  Streams them with the instruction-memory byte address each word is written to.
//  Used by the program loader and the testbench to build instruction memory images.
// PARAMETERS
//  DEPTH      4       FIFO entries; power of 2, >=2
//  BASE_ADDR  32'h0   byte address assigned to the first word popped after reset
// PORTS
//  CLK        in   1   clock, all state updates on posedge
//  Reset      in   1   synchronous, active-high reset
//  in_valid   in   1   field set present on inputs
//  in_ready   out  1   encoder can accept a field set this cycle
//  fmt        in   2   00=R, 01=I, 10=J, 11=reserved
//  opCode     in   6   instruction bits [31:26]
//  rs         in   5   R/I bits [25:21]
//  rt         in   5   R/I bits [20:16]
//  rd         in   5   R bits [15:11]
//  sa         in   5   R bits [10:6]
//  Immediate  in   16  I bits [15:0]
//  j_addr     in   26  J bits [25:0]
//  Ins        out  32  encoded word at FIFO head
//  InsAddr    out  32  byte address of the word on Ins
//  out_valid  out  1   Ins/InsAddr valid
//  out_ready  in   1   consumer takes the head word this cycle
//  level      out  $clog2(DEPTH)+1   current FIFO occupancy
//  fmt_err    out  1   sticky: a reserved-fmt field set was accepted
// BEHAVIOUR
//  - Encoding (combinational on the inputs, stored at push):
//      R = {opCode, rs, rt, rd, sa, 6'b0}
//      I = {opCode, rs, rt, Immediate}
//      J = {opCode, j_addr}
//    Fields unused by the selected format are ignored.
//  - in_ready = (level < DEPTH), combinational from state only.
//  - Push: in_valid && in_ready at posedge.
//  - Pop: out_valid && out_ready at posedge.
//  - out_valid = (level != 0). Ins is the head entry, registered.
//  - Latency: a word pushed at edge N is visible on Ins with out_valid=1 after edge N.
//    There is no same-cycle bypass.
//  - Simultaneous push and pop:
//      level unchanged; both happen.
//      When full, in_ready=0, so there is no push; the pop frees a slot for the next cycle.
//      When empty, there is no pop (out_valid=0); the push occurs.
//  - Reserved fmt (11): the field set is consumed (handshake completes).
//    Nothing is pushed and fmt_err is set to 1. fmt_err is cleared only by Reset.
//  - InsAddr: starts at BASE_ADDR and advances +4 on each pop.
//    It wraps modulo 2^32 (32'hFFFFFFFC -> 32'h0). Pushes do not change it.
//  - Read/write pointers wrap modulo DEPTH. level is never > DEPTH and never < 0.
//  - Holding: while out_valid=1 and out_ready=0, Ins and InsAddr stay stable.
//  - Reset (any cycle, including mid-stream):
//      level=0, pointers=0, out_valid=0, in_ready=1 (after reset deasserts),
//      Ins=32'h0, InsAddr=BASE_ADDR, fmt_err=0.
//    Buffered words are discarded. A handshake coincident with Reset is ignored.
//  - No X propagation: FIFO storage is reset to 0.
// TESTING
//  1. R: op=6'h00 rs=1 rt=2 rd=3 sa=0 -> Ins=32'h00221800, InsAddr=BASE_ADDR, one cycle after push.
//  2. R with shift amount: op=6'h18 rs=0 rt=1 rd=2 sa=2 -> Ins=32'h60011080.
//  3. I then J, back-to-back:
//       I: op=6'h01 rs=1 rt=2 imm=16'hFFFF -> 32'h0422FFFF at addr 0
//       J: op=6'h38 j_addr=26'h10 -> 32'hE0000010 at addr 4
//     Pushes are in consecutive cycles with out_ready=1.
//  4. Full/backpressure, DEPTH=4, out_ready=0: push 5 sets.
//       - in_ready drops after the 4th push; level=4; the 5th is held.
//       - Raise out_ready: words emerge in order at addrs 0,4,8,12.
//       - The 5th is accepted the cycle after the first pop.
//  5. fmt=11 push -> no output word, level unchanged, fmt_err=1 until Reset.
//     BASE_ADDR=32'hFFFFFFFC: two pops -> InsAddr FFFFFFFC then 00000000.
//  6. Reset asserted with level=3 mid-stream -> next cycle:
//       level=0, out_valid=0, InsAddr=BASE_ADDR, fmt_err=0.
//     A subsequent push is encoded normally.

Source files
------------

// File: rtl/ins_encoder.sv
// Instruction field encoder: packs R/I/J field sets into 32-bit words, buffers them
// in a small FIFO and streams each word with its instruction-memory byte address.
module ins_encoder #(
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic                     CLK,
    input  logic                     Reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               fmt,
    input  logic [5:0]               opCode,
    input  logic [4:0]               rs,
    input  logic [4:0]               rt,
    input  logic [4:0]               rd,
    input  logic [4:0]               sa,
    input  logic [15:0]              Immediate,
    input  logic [25:0]              j_addr,
    output logic [31:0]              Ins,
    output logic [31:0]              InsAddr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     fmt_err
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0]   FULL    = (PW + 1)'(DEPTH);
    localparam logic [PW:0]   LVL_ONE = (PW + 1)'(1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    typedef enum logic [1:0] {
        FMT_R   = 2'b00,
        FMT_I   = 2'b01,
        FMT_J   = 2'b10,
        FMT_RSV = 2'b11
    } fmt_t;

    logic [31:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [31:0]   word;
    logic          accept;
    logic          push;
    logic          pop;

    always_comb begin
        word = '0;
        case (fmt_t'(fmt))
            FMT_R:   word = {opCode, rs, rt, rd, sa, 6'b0};
            FMT_I:   word = {opCode, rs, rt, Immediate};
            FMT_J:   word = {opCode, j_addr};
            default: word = '0;
        endcase
    end

    assign in_ready  = (level != FULL);
    assign out_valid = (level != '0);
    assign Ins       = mem[rd_ptr];

    // A reserved-format set completes its handshake but never occupies a slot.
    assign accept = in_valid && in_ready;
    assign push   = accept && (fmt != FMT_RSV);
    assign pop    = out_valid && out_ready;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            InsAddr <= BASE_ADDR;
            fmt_err <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= word;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + PTR_ONE;
                InsAddr <= InsAddr + 32'd4;
            end
            if (push && !pop) begin
                level <= level + LVL_ONE;
            end else if (pop && !push) begin
                level <= level - LVL_ONE;
            end
            if (accept && (fmt == FMT_RSV)) begin
                fmt_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ins_encoder.sv
// Directed bench for ins_encoder: table of single-word encodings plus hand-written
// sequences for back-to-back streaming, backpressure, reserved format, wrap and reset.
module tb_ins_encoder;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        in_valid;
    logic [1:0]  fmt;
    logic [5:0]  opCode;
    logic [4:0]  rs, rt, rd, sa;
    logic [15:0] Immediate;
    logic [25:0] j_addr;
    logic        out_ready;

    logic        ir_a, ov_a, err_a;
    logic [31:0] ins_a, addr_a;
    logic [2:0]  lvl_a;
    logic        ir_b, ov_b, err_b;
    logic [31:0] ins_b, addr_b;
    logic [2:0]  lvl_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    ins_encoder #(.DEPTH(4), .BASE_ADDR(32'h0)) dut_a (
        .CLK(CLK), .Reset(Reset), .in_valid(in_valid), .in_ready(ir_a), .fmt(fmt),
        .opCode(opCode), .rs(rs), .rt(rt), .rd(rd), .sa(sa), .Immediate(Immediate),
        .j_addr(j_addr), .Ins(ins_a), .InsAddr(addr_a), .out_valid(ov_a),
        .out_ready(out_ready), .level(lvl_a), .fmt_err(err_a)
    );

    ins_encoder #(.DEPTH(4), .BASE_ADDR(32'hFFFF_FFFC)) dut_b (
        .CLK(CLK), .Reset(Reset), .in_valid(in_valid), .in_ready(ir_b), .fmt(fmt),
        .opCode(opCode), .rs(rs), .rt(rt), .rd(rd), .sa(sa), .Immediate(Immediate),
        .j_addr(j_addr), .Ins(ins_b), .InsAddr(addr_b), .out_valid(ov_b),
        .out_ready(out_ready), .level(lvl_b), .fmt_err(err_b)
    );

    typedef struct {
        logic [1:0]  f;
        logic [5:0]  op;
        logic [4:0]  s, t, d, sh;
        logic [15:0] imm;
        logic [25:0] ja;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // All driving and sampling happens 1 time unit after the rising edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [1:0] f, input logic [5:0] op, input logic [4:0] s,
                         input logic [4:0] t, input logic [4:0] d, input logic [4:0] sh,
                         input logic [15:0] imm, input logic [25:0] ja);
        in_valid  = 1'b1;
        fmt       = f;
        opCode    = op;
        rs        = s;
        rt        = t;
        rd        = d;
        sa        = sh;
        Immediate = imm;
        j_addr    = ja;
    endtask

    task automatic do_reset();
        Reset    = 1'b1;
        in_valid = 1'b0;
        step();
        step();
        Reset = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_addr;

        vecs[0] = '{2'b00, 6'h00, 5'd1,  5'd2, 5'd3,  5'd0,  16'h0000, 26'h0,       32'h0022_1800};
        vecs[1] = '{2'b00, 6'h18, 5'd0,  5'd1, 5'd2,  5'd2,  16'hABCD, 26'h3FF_FFFF, 32'h6001_1080};
        vecs[2] = '{2'b01, 6'h01, 5'd1,  5'd2, 5'd31, 5'd31, 16'hFFFF, 26'h0,       32'h0422_FFFF};
        vecs[3] = '{2'b10, 6'h38, 5'd31, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h10,     32'hE000_0010};
        vecs[4] = '{2'b01, 6'h23, 5'd31, 5'd5, 5'd0,  5'd0,  16'h1234, 26'h0,       32'h8FE5_1234};

        Reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        fmt = '0; opCode = '0; rs = '0; rt = '0; rd = '0; sa = '0; Immediate = '0; j_addr = '0;
        do_reset();

        chk("rst_level",    32'(lvl_a), 32'd0);
        chk("rst_out_valid", 32'(ov_a), 32'd0);
        chk("rst_in_ready",  32'(ir_a), 32'd1);
        chk("rst_ins",       ins_a,     32'h0);
        chk("rst_addr",      addr_a,    32'h0);
        chk("rst_addr_b",    addr_b,    32'hFFFF_FFFC);
        chk("rst_fmt_err",   32'(err_a), 32'd0);

        // Table: one push, check one cycle later, then pop.
        exp_addr = 32'h0;
        for (int i = 0; i < 5; i++) begin
            drive(vecs[i].f, vecs[i].op, vecs[i].s, vecs[i].t, vecs[i].d, vecs[i].sh,
                  vecs[i].imm, vecs[i].ja);
            out_ready = 1'b0;
            step();
            in_valid = 1'b0;
            chk($sformatf("vec%0d_ins", i),   ins_a, vecs[i].exp);
            chk($sformatf("vec%0d_valid", i), 32'(ov_a), 32'd1);
            chk($sformatf("vec%0d_addr", i),  addr_a, exp_addr);
            chk($sformatf("vec%0d_level", i), 32'(lvl_a), 32'd1);
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            exp_addr += 32'd4;
            chk($sformatf("vec%0d_empty", i), 32'(ov_a), 32'd0);
        end
        chk("vec_addr_after", addr_a, 32'd20);

        // Back-to-back I then J with consumer always ready.
        do_reset();
        out_ready = 1'b1;
        drive(2'b01, 6'h01, 5'd1, 5'd2, 5'd0, 5'd0, 16'hFFFF, 26'h0);
        step();
        chk("b2b_i_ins",  ins_a,  32'h0422_FFFF);
        chk("b2b_i_addr", addr_a, 32'h0);
        drive(2'b10, 6'h38, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10);
        step();
        in_valid = 1'b0;
        chk("b2b_j_ins",   ins_a,  32'hE000_0010);
        chk("b2b_j_addr",  addr_a, 32'h4);
        chk("b2b_j_level", 32'(lvl_a), 32'd1);
        step();
        chk("b2b_drain", 32'(ov_a), 32'd0);
        out_ready = 1'b0;

        // Backpressure: five pushes into a 4-deep FIFO.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(2'b00, 6'h0, 5'd0, 5'd0, 5'(k + 1), 5'd0, 16'h0, 26'h0);
            chk($sformatf("full_ready%0d", k), 32'(ir_a), 32'd1);
            step();
        end
        chk("full_level", 32'(lvl_a), 32'd4);
        chk("full_ready", 32'(ir_a), 32'd0);
        drive(2'b00, 6'h0, 5'd0, 5'd0, 5'd5, 5'd0, 16'h0, 26'h0);
        step();
        step();
        chk("full_hold_level", 32'(lvl_a), 32'd4);
        chk("full_hold_ins",   ins_a, 32'h0000_0800);
        chk("full_hold_addr",  addr_a, 32'h0);
        out_ready = 1'b1;
        step();
        chk("bp_pop1_ins",   ins_a, 32'h0000_1000);
        chk("bp_pop1_addr",  addr_a, 32'h4);
        chk("bp_pop1_level", 32'(lvl_a), 32'd3);
        chk("bp_pop1_ready", 32'(ir_a), 32'd1);
        step();
        in_valid = 1'b0;
        chk("bp_pop2_ins",   ins_a, 32'h0000_1800);
        chk("bp_pop2_addr",  addr_a, 32'h8);
        chk("bp_pop2_level", 32'(lvl_a), 32'd3);
        step();
        chk("bp_pop3_ins",  ins_a, 32'h0000_2000);
        chk("bp_pop3_addr", addr_a, 32'hC);
        step();
        chk("bp_pop4_ins",   ins_a, 32'h0000_2800);
        chk("bp_pop4_addr",  addr_a, 32'h10);
        chk("bp_pop4_level", 32'(lvl_a), 32'd1);
        step();
        chk("bp_empty", 32'(lvl_a), 32'd0);
        out_ready = 1'b0;

        // Reserved format, then address wrap on the high-base instance.
        do_reset();
        drive(2'b11, 6'h3F, 5'd1, 5'd1, 5'd1, 5'd1, 16'h1, 26'h1);
        chk("rsv_ready", 32'(ir_a), 32'd1);
        step();
        in_valid = 1'b0;
        chk("rsv_level",   32'(lvl_a), 32'd0);
        chk("rsv_valid",   32'(ov_a), 32'd0);
        chk("rsv_err",     32'(err_a), 32'd1);
        drive(2'b10, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h1);
        step();
        drive(2'b10, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h2);
        step();
        in_valid = 1'b0;
        chk("rsv_err_sticky", 32'(err_a), 32'd1);
        chk("wrap_addr0",     addr_b, 32'hFFFF_FFFC);
        chk("wrap_ins0",      ins_b,  32'h0800_0001);
        out_ready = 1'b1;
        step();
        chk("wrap_addr1", addr_b, 32'h0);
        chk("wrap_ins1",  ins_b,  32'h0800_0002);
        step();
        out_ready = 1'b0;
        chk("wrap_addr2", addr_b, 32'h4);

        // Reset mid-stream with three words buffered and a coincident handshake.
        do_reset();
        drive(2'b11, 6'h0, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
        step();
        for (int k = 0; k < 3; k++) begin
            drive(2'b01, 6'h04, 5'd0, 5'd0, 5'd0, 5'd0, 16'(k + 7), 26'h0);
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("mid_level_pre", 32'(lvl_a), 32'd2);
        drive(2'b01, 6'h04, 5'd0, 5'd0, 5'd0, 5'd0, 16'hAAAA, 26'h0);
        step();
        in_valid = 1'b0;
        chk("mid_level3", 32'(lvl_a), 32'd3);
        chk("mid_err",    32'(err_a), 32'd1);
        Reset = 1'b1;
        out_ready = 1'b1;
        drive(2'b00, 6'h0, 5'd1, 5'd1, 5'd1, 5'd1, 16'h0, 26'h0);
        step();
        Reset = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("mrst_level", 32'(lvl_a), 32'd0);
        chk("mrst_valid", 32'(ov_a), 32'd0);
        chk("mrst_addr",  addr_a, 32'h0);
        chk("mrst_err",   32'(err_a), 32'd0);
        chk("mrst_ins",   ins_a, 32'h0);
        drive(2'b00, 6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
        step();
        in_valid = 1'b0;
        chk("post_rst_ins",  ins_a, 32'h0022_1800);
        chk("post_rst_addr", addr_a, 32'h0);
        chk("post_rst_lvl",  32'(lvl_a), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
